// File: rtl/neuron_mac_seq.sv
// Single-neuron multiply-accumulate sequencer: sweeps the shared weight/activation BRAM
// address, accumulates weight*activation, adds bias, saturates, applies optional ReLU.
//
// state  | meaning
// IDLE   | waiting for START; BRAMs disabled
// RUN    | presenting addresses 0..N_TAPS-1, one per cycle
// FLUSH1 | last product entering the accumulator
// FLUSH2 | bias add, saturation, ReLU; result registered
// HOLD   | RESULT/OUT_VALID held until OUT_READY
module neuron_mac_seq #(
    parameter int N_TAPS    = 28,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 40
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              START,
    input  logic [DATA_W-1:0] BIAS,
    input  logic              RELU_EN,
    output logic [ADDR_W-1:0] ADDR,
    output logic              EN,
    output logic              WE,
    input  logic [DATA_W-1:0] W_DO,
    input  logic [DATA_W-1:0] X_DO,
    output logic              BUSY,
    output logic [DATA_W-1:0] RESULT,
    output logic              OUT_VALID,
    input  logic              OUT_READY
);

    localparam int PROD_W = 2 * DATA_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_TAPS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_FLUSH1 = 3'd2,
        S_FLUSH2 = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] addr_nxt;
    logic              en_nxt;
    logic              busy_nxt;
    logic              valid_nxt;
    logic [DATA_W-1:0] result_nxt;
    logic [DATA_W-1:0] bias_q, bias_nxt;
    logic              relu_q, relu_nxt;
    logic              acc_clr;

    logic signed [PROD_W-1:0] prod;
    logic                     prod_v;
    logic signed [ACC_W-1:0]  acc;

    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  shifted;
    logic [DATA_W-1:0]        res_calc;

    assign WE = 1'b0;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state     <= S_IDLE;
            ADDR      <= '0;
            EN        <= 1'b0;
            BUSY      <= 1'b0;
            OUT_VALID <= 1'b0;
            RESULT    <= '0;
            bias_q    <= '0;
            relu_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            ADDR      <= addr_nxt;
            EN        <= en_nxt;
            BUSY      <= busy_nxt;
            OUT_VALID <= valid_nxt;
            RESULT    <= result_nxt;
            bias_q    <= bias_nxt;
            relu_q    <= relu_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        addr_nxt   = ADDR;
        en_nxt     = EN;
        busy_nxt   = BUSY;
        valid_nxt  = OUT_VALID;
        result_nxt = RESULT;
        bias_nxt   = bias_q;
        relu_nxt   = relu_q;
        acc_clr    = 1'b0;
        case (state)
            S_IDLE: begin
                if (START) begin
                    state_nxt = S_RUN;
                    addr_nxt  = '0;
                    en_nxt    = 1'b1;
                    busy_nxt  = 1'b1;
                    acc_clr   = 1'b1;
                    bias_nxt  = BIAS;
                    relu_nxt  = RELU_EN;
                end
            end
            S_RUN: begin
                if (ADDR == LAST_ADDR) begin
                    state_nxt = S_FLUSH1;
                    en_nxt    = 1'b0;
                    addr_nxt  = '0;
                end else begin
                    addr_nxt = ADDR + 1'b1;
                end
            end
            S_FLUSH1: state_nxt = S_FLUSH2;
            S_FLUSH2: begin
                result_nxt = res_calc;
                valid_nxt  = 1'b1;
                state_nxt  = S_HOLD;
            end
            S_HOLD: begin
                if (OUT_READY) begin
                    valid_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Products are valid one cycle after EN; the accumulator lags one more cycle.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            prod   <= '0;
            prod_v <= 1'b0;
            acc    <= '0;
        end else begin
            prod_v <= EN;
            if (EN) begin
                prod <= $signed(W_DO) * $signed(X_DO);
            end
            if (acc_clr) begin
                acc <= '0;
            end else if (prod_v) begin
                acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
            end
        end
    end

    always_comb begin
        bias_ext = {{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q} <<< FRAC_BITS;
        sum      = acc + bias_ext;
        shifted  = sum >>> FRAC_BITS;
        if (shifted[ACC_W-1:DATA_W-1] == {(ACC_W-DATA_W+1){shifted[ACC_W-1]}}) begin
            res_calc = shifted[DATA_W-1:0];
        end else if (shifted[ACC_W-1]) begin
            res_calc = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            res_calc = {1'b0, {(DATA_W-1){1'b1}}};
        end
        if (relu_q && res_calc[DATA_W-1]) begin
            res_calc = '0;
        end
    end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed bench for neuron_mac_seq with a negedge-updating BRAM model.
module tb_neuron_mac_seq;

    localparam int N_TAPS = 28;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        START;
    logic [15:0] BIAS;
    logic        RELU_EN;
    logic [4:0]  ADDR;
    logic        EN;
    logic        WE;
    logic [15:0] W_DO = '0;
    logic [15:0] X_DO = '0;
    logic        BUSY;
    logic [15:0] RESULT;
    logic        OUT_VALID;
    logic        OUT_READY;

    logic [15:0] w_mem [0:31];
    logic [15:0] x_mem [0:31];

    int vectors = 0;
    int miscompares = 0;

    neuron_mac_seq dut (
        .CLK(CLK), .RSTN(RSTN), .START(START), .BIAS(BIAS), .RELU_EN(RELU_EN),
        .ADDR(ADDR), .EN(EN), .WE(WE), .W_DO(W_DO), .X_DO(X_DO), .BUSY(BUSY),
        .RESULT(RESULT), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (EN === 1'b1) begin
            W_DO <= w_mem[ADDR];
            X_DO <= x_mem[ADDR];
        end
    end

    task automatic fill(input logic [15:0] w, input logic [15:0] x);
        for (int i = 0; i < 32; i++) begin
            w_mem[i] = (i < N_TAPS) ? w : 16'h1234;
            x_mem[i] = (i < N_TAPS) ? x : 16'h4321;
        end
    endtask

    // Starts a run, scrambles BIAS/RELU_EN after capture, waits (bounded) for OUT_VALID.
    task automatic run_mac(input logic [15:0] bias, input logic relu,
                           output int lat, output int en_cnt, output int addr_err);
        lat = -1;
        en_cnt = 0;
        addr_err = 0;
        BIAS = bias;
        RELU_EN = relu;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        BIAS = ~bias;
        RELU_EN = ~relu;
        if (EN === 1'b1) begin
            if (ADDR !== en_cnt[4:0]) addr_err++;
            en_cnt++;
        end
        for (int n = 1; n <= 40; n++) begin
            @(posedge CLK); #1;
            if (EN === 1'b1) begin
                if (ADDR !== en_cnt[4:0]) addr_err++;
                en_cnt++;
            end
            if (OUT_VALID === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic accept();
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({ADDR, EN, WE, BUSY, OUT_VALID} !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got addr=%0d en=%b we=%b busy=%b valid=%b, want all 0",
                     ADDR, EN, WE, BUSY, OUT_VALID);
        end
        vectors++;
        if (RESULT !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_result: got %h want 0000", RESULT);
        end
        @(negedge CLK) RSTN = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_basic();
        int lat, en_cnt, addr_err;
        fill(16'h0100, 16'h0100);
        run_mac(16'h0000, 1'b0, lat, en_cnt, addr_err);
        vectors++;
        if (lat != 30) begin
            miscompares++;
            $display("FAIL t1_latency: got %0d edges want 30", lat);
        end
        vectors++;
        if (RESULT !== 16'h1C00) begin
            miscompares++;
            $display("FAIL t1_result: got %h want 1c00", RESULT);
        end
        vectors++;
        if (BUSY !== 1'b1 || WE !== 1'b0) begin
            miscompares++;
            $display("FAIL t1_busy_we: got busy=%b we=%b want busy=1 we=0", BUSY, WE);
        end
        accept();
    endtask

    task automatic test_saturation();
        int lat, en_cnt, addr_err;
        fill(16'h7FFF, 16'h7FFF);
        run_mac(16'h0000, 1'b0, lat, en_cnt, addr_err);
        vectors++;
        if (lat != 30 || RESULT !== 16'h7FFF) begin
            miscompares++;
            $display("FAIL t2_pos_sat: got %h lat %0d want 7fff lat 30", RESULT, lat);
        end
        accept();
        fill(16'h8000, 16'h7FFF);
        run_mac(16'h0000, 1'b0, lat, en_cnt, addr_err);
        vectors++;
        if (lat != 30 || RESULT !== 16'h8000) begin
            miscompares++;
            $display("FAIL t2_neg_sat: got %h lat %0d want 8000 lat 30", RESULT, lat);
        end
        accept();
    endtask

    task automatic test_relu();
        int lat, en_cnt, addr_err;
        fill(16'hFF00, 16'h0100);
        run_mac(16'h0000, 1'b0, lat, en_cnt, addr_err);
        vectors++;
        if (lat != 30 || RESULT !== 16'hE400) begin
            miscompares++;
            $display("FAIL t3_neg_norelu: got %h lat %0d want e400 lat 30", RESULT, lat);
        end
        accept();
        run_mac(16'h0000, 1'b1, lat, en_cnt, addr_err);
        vectors++;
        if (lat != 30 || RESULT !== 16'h0000) begin
            miscompares++;
            $display("FAIL t3_neg_relu: got %h lat %0d want 0000 lat 30", RESULT, lat);
        end
        accept();
    endtask

    task automatic test_bias_sweep();
        int lat, en_cnt, addr_err;
        fill(16'h0000, 16'h7FFF);
        run_mac(16'h0080, 1'b0, lat, en_cnt, addr_err);
        vectors++;
        if (RESULT !== 16'h0080) begin
            miscompares++;
            $display("FAIL t4_bias_only: got %h want 0080", RESULT);
        end
        vectors++;
        if (en_cnt != 28) begin
            miscompares++;
            $display("FAIL t4_en_cycles: got %0d want 28", en_cnt);
        end
        vectors++;
        if (addr_err != 0) begin
            miscompares++;
            $display("FAIL t4_addr_order: got %0d out-of-order addresses want 0", addr_err);
        end
        accept();
    endtask

    // Per-tap data: w = i.0, x = 1/16, bias = -1.0 -> 378/16 - 1 = 22.625 = 0x16A0.
    task automatic test_mixed_taps();
        int lat, en_cnt, addr_err;
        fill(16'h0000, 16'h0010);
        for (int i = 0; i < N_TAPS; i++) w_mem[i] = 16'(i << 8);
        run_mac(16'hFF00, 1'b0, lat, en_cnt, addr_err);
        vectors++;
        if (lat != 30 || RESULT !== 16'h16A0) begin
            miscompares++;
            $display("FAIL mixed_taps: got %h lat %0d want 16a0 lat 30", RESULT, lat);
        end
        accept();
    endtask

    // Sum of -28 LSBs shifted right truncates toward -inf to -1 LSB.
    task automatic test_truncation();
        int lat, en_cnt, addr_err;
        fill(16'hFFFF, 16'h0001);
        run_mac(16'h0000, 1'b0, lat, en_cnt, addr_err);
        vectors++;
        if (RESULT !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL trunc_neg: got %h want ffff", RESULT);
        end
        accept();
        run_mac(16'h0000, 1'b1, lat, en_cnt, addr_err);
        vectors++;
        if (RESULT !== 16'h0000) begin
            miscompares++;
            $display("FAIL trunc_relu: got %h want 0000", RESULT);
        end
        accept();
    endtask

    task automatic test_back_to_back();
        int lat, en_cnt, addr_err;
        fill(16'h0100, 16'h0100);
        run_mac(16'h0000, 1'b0, lat, en_cnt, addr_err);
        for (int c = 0; c < 5; c++) begin
            START = (c % 2 == 0);
            @(posedge CLK); #1;
            vectors++;
            if (OUT_VALID !== 1'b1 || RESULT !== 16'h1C00 || EN !== 1'b0 || BUSY !== 1'b1) begin
                miscompares++;
                $display("FAIL t5_hold_c%0d: got valid=%b res=%h en=%b busy=%b want 1/1c00/0/1",
                         c, OUT_VALID, RESULT, EN, BUSY);
            end
        end
        START = 1'b1;
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        OUT_READY = 1'b0;
        vectors++;
        if (OUT_VALID !== 1'b0 || BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL t5_handshake: got valid=%b busy=%b want 0/0", OUT_VALID, BUSY);
        end
        @(posedge CLK); #1;
        vectors++;
        if (EN !== 1'b0 || BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL t5_no_restart: got en=%b busy=%b want 0/0", EN, BUSY);
        end
    endtask

    task automatic test_reset_midrun();
        int lat, en_cnt, addr_err;
        bit found;
        found = 1'b0;
        fill(16'h0100, 16'h0100);
        BIAS = 16'h0000;
        RELU_EN = 1'b0;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (ADDR === 5'd10 && EN === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(posedge CLK); #1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL t6_reach_addr10: got addr=%0d en=%b want addr=10 en=1", ADDR, EN);
        end
        #2 RSTN = 1'b0;
        #1;
        vectors++;
        if (EN !== 1'b0 || BUSY !== 1'b0 || OUT_VALID !== 1'b0 || ADDR !== 5'd0) begin
            miscompares++;
            $display("FAIL t6_async_reset: got en=%b busy=%b valid=%b addr=%0d want 0/0/0/0",
                     EN, BUSY, OUT_VALID, ADDR);
        end
        @(negedge CLK) RSTN = 1'b1;
        @(posedge CLK); #1;
        vectors++;
        if (EN !== 1'b0 || BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL t6_idle_after: got en=%b busy=%b want 0/0", EN, BUSY);
        end
        run_mac(16'h0000, 1'b0, lat, en_cnt, addr_err);
        vectors++;
        if (lat != 30 || RESULT !== 16'h1C00) begin
            miscompares++;
            $display("FAIL t6_rerun: got %h lat %0d want 1c00 lat 30", RESULT, lat);
        end
        accept();
    endtask

    initial begin
        RSTN = 1'b0;
        START = 1'b0;
        BIAS = '0;
        RELU_EN = 1'b0;
        OUT_READY = 1'b0;
        fill(16'h0000, 16'h0000);
        test_reset();
        test_basic();
        test_saturation();
        test_relu();
        test_bias_sweep();
        test_mixed_taps();
        test_truncation();
        test_back_to_back();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
